// File: rtl/jk_arb_pkg.sv
// Shared encodings for the JK bank arbiter: JK operations and sequencer states.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Operations are encoded as {J,K}
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop of the shared bank: rising-edge update, asynchronous active-low clear.
module jk_cell
    import jk_arb_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                OP_HOLD: q <= q;
                OP_CLR:  q <= 1'b0;
                OP_SET:  q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_arb.sv
// Two-requester arbiter/sequencer driving a shared WIDTH-bit JK bank, one op per 3 cycles.
// Define JK_ARB_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting; samples REQ0/REQ1, latches winner's OP and MASK
// ST_EXEC | grant to winner, J/K applied, bank updates at end of cycle
// ST_DONE | acknowledge winner, J=K=0, last-served pointer updated
module jk_bank_arb
    import jk_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [1:0]       OP0,
    input  logic [1:0]       OP1,
    input  logic [WIDTH-1:0] MASK0,
    input  logic [WIDTH-1:0] MASK1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ACK0,
    output logic             ACK1,
    output logic             BUSY,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
);

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             pick1;

`ifdef JK_ARB_PRIO_EN
    assign pick1 = REQ1 & ~REQ0;
`else
    // Reset value 1 makes requester 0 win the first tie
    logic last_q;

    assign pick1 = REQ1 & (~REQ0 | ~last_q);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            last_q <= 1'b1;
        end else if (state_q == ST_DONE) begin
            last_q <= win_q;
        end
    end
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            op_q    <= OP_HOLD;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        mask_d  = mask_q;
        GNT0    = 1'b0;
        GNT1    = 1'b0;
        ACK0    = 1'b0;
        ACK1    = 1'b0;
        J       = '0;
        K       = '0;
        case (state_q)
            ST_IDLE: begin
                if (REQ0 | REQ1) begin
                    win_d   = pick1;
                    op_d    = pick1 ? OP1 : OP0;
                    mask_d  = pick1 ? MASK1 : MASK0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                GNT0    = ~win_q;
                GNT1    = win_q;
                J       = mask_q & {WIDTH{op_q[1]}};
                K       = mask_q & {WIDTH{op_q[0]}};
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ACK0    = ~win_q;
                ACK1    = win_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY = (state_q != ST_IDLE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        jk_cell u_cell (
            .clk(CLK),
            .clr(CLR),
            .j  (J[i]),
            .k  (K[i]),
            .q  (Q[i])
        );
    end

    assign QN = ~Q;

endmodule

// File: tb/tb_jk_bank_arb.sv
// Directed self-checking bench for jk_bank_arb; outputs sampled on the falling clock edge.
module tb_jk_bank_arb;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         CLR;
    logic         REQ0, REQ1;
    logic [1:0]   OP0, OP1;
    logic [W-1:0] MASK0, MASK1;
    logic         GNT0, GNT1, ACK0, ACK1, BUSY;
    logic [W-1:0] J, K, Q, QN;

    int checks = 0;
    int errors = 0;

    jk_bank_arb #(.WIDTH(W)) dut (
        .CLK(CLK), .CLR(CLR),
        .REQ0(REQ0), .REQ1(REQ1),
        .OP0(OP0), .OP1(OP1),
        .MASK0(MASK0), .MASK1(MASK1),
        .GNT0(GNT0), .GNT1(GNT1),
        .ACK0(ACK0), .ACK1(ACK1),
        .BUSY(BUSY),
        .J(J), .K(K), .Q(Q), .QN(QN)
    );

    always #5 CLK = ~CLK;

    task automatic test_reset();
        CLR = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
        OP0 = 2'b00; OP1 = 2'b00; MASK0 = '0; MASK1 = '0;
        @(negedge CLK); @(negedge CLK);
        checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL reset_q got %b want 0000", Q); end
        checks++; if (QN !== 4'b1111) begin errors++; $display("FAIL reset_qn got %b want 1111", QN); end
        checks++; if ({GNT0, GNT1, ACK0, ACK1, BUSY} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b want 00000", {GNT0, GNT1, ACK0, ACK1, BUSY}); end
        checks++; if ({J, K} !== 8'h00) begin errors++; $display("FAIL reset_jk got %h want 00", {J, K}); end
        CLR = 1'b1;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", BUSY); end
    endtask

    task automatic test_single_op();
        REQ0 = 1'b1; OP0 = 2'b10; MASK0 = 4'b0101;
        @(negedge CLK);
        checks++; if ({GNT0, GNT1, BUSY, ACK0} !== 4'b1010) begin errors++; $display("FAIL single_exec_ctl got %b want 1010", {GNT0, GNT1, BUSY, ACK0}); end
        checks++; if (J !== 4'b0101 || K !== 4'b0000) begin errors++; $display("FAIL single_exec_jk got J=%b K=%b want J=0101 K=0000", J, K); end
        @(negedge CLK);
        checks++; if ({GNT0, ACK0, ACK1, BUSY} !== 4'b0101) begin errors++; $display("FAIL single_done_ctl got %b want 0101", {GNT0, ACK0, ACK1, BUSY}); end
        checks++; if (Q !== 4'b0101 || QN !== 4'b1010) begin errors++; $display("FAIL single_q got Q=%b QN=%b want 0101/1010", Q, QN); end
        checks++; if (J !== 4'b0000 || K !== 4'b0000) begin errors++; $display("FAIL single_done_jk got J=%b K=%b want 0000", J, K); end
        REQ0 = 1'b0;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0 || ACK0 !== 1'b0) begin errors++; $display("FAIL single_idle got BUSY=%b ACK0=%b want 0 0", BUSY, ACK0); end
    endtask

    task automatic test_toggle_clear();
        REQ1 = 1'b1; OP1 = 2'b11; MASK1 = 4'b1111;
        @(negedge CLK);
        checks++; if ({GNT0, GNT1} !== 2'b01) begin errors++; $display("FAIL tgl_gnt got %b want 01", {GNT0, GNT1}); end
        checks++; if (J !== 4'b1111 || K !== 4'b1111) begin errors++; $display("FAIL tgl_jk got J=%b K=%b want 1111 1111", J, K); end
        @(negedge CLK);
        checks++; if ({ACK0, ACK1} !== 2'b01) begin errors++; $display("FAIL tgl_ack got %b want 01", {ACK0, ACK1}); end
        checks++; if (Q !== 4'b1010) begin errors++; $display("FAIL tgl_q got %b want 1010", Q); end
        OP1 = 2'b01; MASK1 = 4'b0010;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_idle got BUSY=%b want 0", BUSY); end
        @(negedge CLK);
        checks++; if (GNT1 !== 1'b1 || K !== 4'b0010 || J !== 4'b0000) begin errors++; $display("FAIL clr_exec got GNT1=%b J=%b K=%b want 1 0000 0010", GNT1, J, K); end
        @(negedge CLK);
        checks++; if (ACK1 !== 1'b1 || Q !== 4'b1000) begin errors++; $display("FAIL clr_q got ACK1=%b Q=%b want 1 1000", ACK1, Q); end
        REQ1 = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_late_change();
        REQ0 = 1'b1; OP0 = 2'b10; MASK0 = 4'b0001;
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b1) begin errors++; $display("FAIL late_gnt got %b want 1", GNT0); end
        OP0 = 2'b01; MASK0 = 4'b1111;
        #1;
        checks++; if (J !== 4'b0001 || K !== 4'b0000) begin errors++; $display("FAIL late_jk got J=%b K=%b want 0001 0000", J, K); end
        @(negedge CLK);
        checks++; if (ACK0 !== 1'b1 || Q !== 4'b1001) begin errors++; $display("FAIL late_q got ACK0=%b Q=%b want 1 1001", ACK0, Q); end
        REQ0 = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_hold_op();
        REQ0 = 1'b1; OP0 = 2'b00; MASK0 = 4'b1111;
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b1 || BUSY !== 1'b1 || {J, K} !== 8'h00) begin errors++; $display("FAIL hold_exec got GNT0=%b BUSY=%b JK=%h want 1 1 00", GNT0, BUSY, {J, K}); end
        @(negedge CLK);
        checks++; if (ACK0 !== 1'b1 || Q !== 4'b1001) begin errors++; $display("FAIL hold_done got ACK0=%b Q=%b want 1 1001", ACK0, Q); end
        REQ0 = 1'b0;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0 || ACK0 !== 1'b0) begin errors++; $display("FAIL hold_idle got BUSY=%b ACK0=%b want 0 0", BUSY, ACK0); end
    endtask

    task automatic test_tie();
        int seq[4];
        int exp_seq[4];
        int n = 0;
        logic [W-1:0] exp_q;
`ifdef JK_ARB_PRIO_EN
        exp_seq = '{0, 0, 0, 0};
        exp_q   = 4'b0001;
`else
        exp_seq = '{0, 1, 0, 1};
        exp_q   = 4'b0011;
`endif
        CLR = 1'b0;
        @(negedge CLK);
        CLR = 1'b1;
        REQ0 = 1'b1; OP0 = 2'b10; MASK0 = 4'b0001;
        REQ1 = 1'b1; OP1 = 2'b10; MASK1 = 4'b0010;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge CLK);
            checks++;
            if ((GNT0 & GNT1) | (ACK0 & ACK1) | ((GNT0 | GNT1) & (ACK0 | ACK1))) begin
                errors++; $display("FAIL tie_excl got GNT=%b%b ACK=%b%b", GNT0, GNT1, ACK0, ACK1);
            end
            if (GNT0) begin seq[n] = 0; n++; end
            else if (GNT1) begin seq[n] = 1; n++; end
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL tie_timeout got %0d grants want 4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < n && seq[i] != exp_seq[i]) begin
                errors++; $display("FAIL tie_order[%0d] got %0d want %0d", i, seq[i], exp_seq[i]);
            end
        end
        for (int c = 0; c < 6 && BUSY; c++) @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL tie_drain got BUSY=%b want 0", BUSY); end
        checks++; if (Q !== exp_q) begin errors++; $display("FAIL tie_q got %b want %b", Q, exp_q); end
    endtask

    task automatic test_reset_mid_exec();
        REQ0 = 1'b1; OP0 = 2'b10; MASK0 = 4'b1111;
        @(negedge CLK);
        checks++; if (GNT0 !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt got %b want 1", GNT0); end
        CLR = 1'b0;
        #1;
        checks++; if (Q !== 4'b0000 || QN !== 4'b1111) begin errors++; $display("FAIL rst_mid_q got Q=%b QN=%b want 0000 1111", Q, QN); end
        checks++; if ({BUSY, GNT0, ACK0} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctl got %b want 000", {BUSY, GNT0, ACK0}); end
        @(negedge CLK);
        checks++; if (ACK0 !== 1'b0 || Q !== 4'b0000) begin errors++; $display("FAIL rst_mid_hold got ACK0=%b Q=%b want 0 0000", ACK0, Q); end
        REQ0 = 1'b0;
        CLR = 1'b1;
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0 || ACK0 !== 1'b0 || Q !== 4'b0000) begin errors++; $display("FAIL rst_after got BUSY=%b ACK0=%b Q=%b want 0 0 0000", BUSY, ACK0, Q); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_toggle_clear();
        test_late_change();
        test_hold_op();
        test_tie();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
